sub_bytes_unit: RTL and testbench

SUB_BYTES_UNIT -- requirements
Module: sub_bytes_unit

---
 rtl/sub_bytes_unit.sv | 141 ++++++++++++++
 tb/tb_sub_bytes_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_unit.sv
// AES SubBytes / InvSubBytes over one block, LANES S-box evaluations per clock.
// The S-box is computed as GF(2^8) inversion plus the FIPS-197 affine map.
module sub_bytes_unit #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned NBYTES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                inv,
    input  logic [8*NBYTES-1:0] block_in,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] block_out
);
    localparam int unsigned GROUPS = NBYTES / LANES;
    localparam int unsigned CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8), and maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = b;
        for (int unsigned i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int unsigned n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b, input logic inverse);
        logic [7:0] a;
        logic [7:0] r;
        if (inverse) begin
            a = rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05;
            r = gf_inv(a);
        end else begin
            a = gf_inv(b);
            r = a ^ rotl(a, 1) ^ rotl(a, 2) ^ rotl(a, 3) ^ rotl(a, 4) ^ 8'h63;
        end
        return r;
    endfunction

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [8*NBYTES-1:0] src_q;
    logic [8*NBYTES-1:0] res_q;
    logic [8*NBYTES-1:0] res_d;
    logic [8*NBYTES-1:0] out_q;
    logic                inv_q;
    logic                busy_q;
    logic                done_q;
    logic                last;
    logic [7:0]          lane_in  [LANES];
    logic [7:0]          lane_out [LANES];

    assign last = (cnt_q == CW'(GROUPS - 1));

    // Lane j always serves byte cnt*LANES+j; group select is a constant-index mux.
    always_comb begin
        for (int unsigned j = 0; j < LANES; j++) lane_in[j] = '0;
        for (int unsigned g = 0; g < GROUPS; g++) begin
            if (cnt_q == CW'(g)) begin
                for (int unsigned j = 0; j < LANES; j++)
                    lane_in[j] = src_q[8*(NBYTES-1-(g*LANES+j)) +: 8];
            end
        end
        for (int unsigned j = 0; j < LANES; j++) lane_out[j] = sbox(lane_in[j], inv_q);
        res_d = res_q;
        for (int unsigned g = 0; g < GROUPS; g++) begin
            if (cnt_q == CW'(g)) begin
                for (int unsigned j = 0; j < LANES; j++)
                    res_d[8*(NBYTES-1-(g*LANES+j)) +: 8] = lane_out[j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            res_q   <= '0;
            out_q   <= '0;
            inv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_q   <= block_in;
                        inv_q   <= inv;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q <= res_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        out_q   <= res_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign block_out = out_q;

endmodule

// File: tb/tb_sub_bytes_unit.sv
// Bench for sub_bytes_unit: five instances (LANES 1..16) share stimulus and are
// checked each cycle against a latency-level model built on generated S-box tables.
module tb_sub_bytes_unit;
    localparam int NI = 5;

    logic         clk;
    logic         rst;
    logic         start;
    logic         inv;
    logic [127:0] block_in;
    logic         busy_w [NI];
    logic         done_w [NI];
    logic [127:0] out_w  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sub_bytes_unit #(.LANES(1 << g), .NBYTES(16)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start),
            .inv      (inv),
            .block_in (block_in),
            .busy     (busy_w[g]),
            .done     (done_w[g]),
            .block_out(out_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    logic [7:0] sbox_t  [256];
    logic [7:0] isbox_t [256];

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // Walks the multiplicative group with generator 3 and its inverse in lockstep.
    task automatic build_tables();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
        for (int v = 0; v < 256; v++) isbox_t[sbox_t[v]] = 8'(v);
    endtask

    function automatic logic [127:0] sub_blk(input logic [127:0] b, input bit iv);
        logic [127:0] r;
        for (int k = 0; k < 16; k++)
            r[8*(15-k) +: 8] = iv ? isbox_t[b[8*(15-k) +: 8]] : sbox_t[b[8*(15-k) +: 8]];
        return r;
    endfunction

    bit           m_busy [NI];
    bit           m_done [NI];
    bit           m_inv  [NI];
    int           m_rem  [NI];
    bit [127:0]   m_src  [NI];
    bit [127:0]   m_out  [NI];

    // Model: accept when idle, result appears NBYTES/LANES edges later.
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_busy[i] = 0;
                m_done[i] = 0;
                m_rem[i]  = 0;
                m_out[i]  = '0;
            end else begin
                m_done[i] = 0;
                if (!m_busy[i]) begin
                    if (start) begin
                        m_src[i]  = block_in;
                        m_inv[i]  = inv;
                        m_rem[i]  = 16 >> i;
                        m_busy[i] = 1;
                    end
                end else begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        m_out[i]  = sub_blk(m_src[i], m_inv[i]);
                        m_done[i] = 1;
                        m_busy[i] = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("L%0d busy", 1 << i), 128'(busy_w[i]), 128'(m_busy[i]));
            chk($sformatf("L%0d done", 1 << i), 128'(done_w[i]), 128'(m_done[i]));
            chk($sformatf("L%0d block_out", 1 << i), out_w[i], m_out[i]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input bit iv, input logic [127:0] blk, input logic [127:0] exp,
                             input bit mid, input string nm);
        bit got [NI];
        int lat [NI];
        int n;
        bit all;
        for (int i = 0; i < NI; i++) begin
            got[i] = 0;
            lat[i] = 0;
        end
        inv      = iv;
        block_in = blk;
        start    = 1'b1;
        tick();
        start = 1'b0;
        if (mid) begin
            start    = 1'b1;
            block_in = ~blk;
            inv      = ~iv;
        end
        n   = 0;
        all = 0;
        while (n < 40 && !all) begin
            tick();
            start    = 1'b0;
            block_in = {$urandom, $urandom, $urandom, $urandom};
            inv      = 1'($urandom);
            n++;
            all = 1;
            for (int i = 0; i < NI; i++) begin
                if (!got[i] && done_w[i] === 1'b1) begin
                    got[i] = 1;
                    lat[i] = n;
                end
                if (!got[i]) all = 0;
            end
        end
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s L%0d latency", nm, 1 << i), 128'(lat[i]), 128'(16 >> i));
            chk($sformatf("%s L%0d result", nm, 1 << i), out_w[i], exp);
        end
    endtask

    initial begin
        logic [127:0] b;
        logic [127:0] f;
        int           bad;
        int           nd4;
        int           nd16;
        int           nd_any;

        build_tables();
        rst      = 1'b1;
        start    = 1'b0;
        inv      = 1'b0;
        block_in = '0;

        chk("tab fwd 00", 128'(sbox_t[8'h00]), 128'(8'h63));
        chk("tab fwd 53", 128'(sbox_t[8'h53]), 128'(8'hed));
        chk("tab fwd 01", 128'(sbox_t[8'h01]), 128'(8'h7c));
        chk("tab inv ed", 128'(isbox_t[8'hed]), 128'(8'h53));
        chk("tab inv 09", 128'(isbox_t[8'h09]), 128'(8'h40));
        chk("tab inv 98", 128'(isbox_t[8'h98]), 128'(8'he2));
        chk("tab inv af", 128'(isbox_t[8'haf]), 128'(8'h1b));
        bad = 0;
        for (int v = 0; v < 256; v++) if (isbox_t[sbox_t[v]] !== 8'(v)) bad++;
        chk("tab roundtrip", 128'(bad), 128'(0));

        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset L%0d out", 1 << i), out_w[i], '0);
            chk($sformatf("reset L%0d busy", 1 << i), 128'(busy_w[i]), 128'(0));
        end

        run_block(1'b0, '0, {16{8'h63}}, 1'b0, "zeros");
        run_block(1'b1, {8'h09, 8'h98, 8'haf, {13{8'h63}}}, {8'h40, 8'he2, 8'h1b, {13{8'h00}}},
                  1'b0, "inv vec");

        for (int r = 0; r < 3; r++) begin
            b = {$urandom, $urandom, $urandom, $urandom};
            f = sub_blk(b, 1'b0);
            run_block(1'b0, b, f, 1'b0, "rt fwd");
            run_block(1'b1, f, b, 1'b0, "rt inv");
        end

        b = 128'h00112233_44556677_8899aabb_ccddeeff;
        run_block(1'b0, b, sub_blk(b, 1'b0), 1'b1, "mid start");

        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 16; j++) b[8*(15-j) +: 8] = 8'(16*k + j);
            run_block(1'b0, b, sub_blk(b, 1'b0), 1'b0, "exh fwd");
            if (k == 5) chk("exh fwd 53", 128'(out_w[4][8*12 +: 8]), 128'(8'hed));
            run_block(1'b1, b, sub_blk(b, 1'b1), 1'b0, "exh inv");
            if (k == 14) chk("exh inv ed", 128'(out_w[4][8*2 +: 8]), 128'(8'h53));
        end

        nd4  = 0;
        nd16 = 0;
        start = 1'b1;
        for (int c = 0; c < 30; c++) begin
            block_in = {$urandom, $urandom, $urandom, $urandom};
            inv      = 1'($urandom);
            tick();
            if (done_w[2] === 1'b1) nd4++;
            if (done_w[4] === 1'b1) nd16++;
        end
        start = 1'b0;
        chk("b2b L4 dones", 128'(nd4), 128'(6));
        chk("b2b L16 dones", 128'(nd16), 128'(15));
        repeat (20) tick();

        block_in = {$urandom, $urandom, $urandom, $urandom};
        inv      = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("abort L%0d busy", 1 << i), 128'(busy_w[i]), 128'(0));
            chk($sformatf("abort L%0d done", 1 << i), 128'(done_w[i]), 128'(0));
            chk($sformatf("abort L%0d out", 1 << i), out_w[i], '0);
        end
        tick();
        tick();
        #2 rst = 1'b0;
        nd_any = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            for (int i = 0; i < NI; i++) if (done_w[i] !== 1'b0) nd_any++;
        end
        chk("abort no done", 128'(nd_any), 128'(0));
        run_block(1'b0, '0, {16{8'h63}}, 1'b0, "after abort");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
